// File: rtl/max4_search_ctrl.sv
// Four-operand unique-maximum search: decrements nonzero operands until one survivor or none.
// Optional MAX4_FAST_STEP_EN subtracts the masked minimum each step instead of 1.
module max4_search_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] a2,
    input  logic [WIDTH-1:0] a3,
    output logic             busy,
    output logic             done,
    output logic [1:0]       idx,
    output logic             tie,
    output logic [WIDTH-1:0] max_val,
    output logic [CNT_W-1:0] steps
);

    typedef enum logic [1:0] {st_idle, st_run, st_done} state_t;

    state_t                  state;
    logic [3:0][WIDTH-1:0]   r_q;
    logic [3:0][WIDTH-1:0]   o_q;
    logic [3:0][WIDTH-1:0]   a_all;
    logic [3:0][WIDTH-1:0]   r_dec;
    logic [3:0]              nz;
    logic [1:0]              one_idx;
    logic [WIDTH-1:0]        sub;

    assign a_all = {a3, a2, a1, a0};

    always_comb begin
        nz      = '0;
        one_idx = '0;
        r_dec   = r_q;
        for (int i = 0; i < 4; i++) begin
            nz[i] = |r_q[i];
            if (nz[i]) one_idx = 2'(i);
        end
`ifdef MAX4_FAST_STEP_EN
        // Masked min over nonzero regs; only consumed when at least two are nonzero.
        sub = '1;
        for (int i = 0; i < 4; i++) begin
            if (nz[i] && (r_q[i] < sub)) sub = r_q[i];
        end
`else
        sub = WIDTH'(1);
`endif
        for (int i = 0; i < 4; i++) begin
            if (nz[i]) r_dec[i] = r_q[i] - sub;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= st_idle;
            r_q     <= '0;
            o_q     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            idx     <= '0;
            tie     <= 1'b0;
            max_val <= '0;
            steps   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                st_idle: begin
                    if (start) begin
                        r_q   <= a_all;
                        o_q   <= a_all;
                        steps <= '0;
                        tie   <= 1'b0;
                        busy  <= 1'b1;
                        state <= st_run;
                    end
                end
                st_run: begin
                    if ($onehot(nz)) begin
                        idx     <= one_idx;
                        max_val <= o_q[one_idx];
                        tie     <= 1'b0;
                        state   <= st_done;
                    end else if (nz == 4'b0000) begin
                        idx     <= '0;
                        max_val <= '0;
                        tie     <= 1'b1;
                        state   <= st_done;
                    end else begin
                        r_q <= r_dec;
                        if (steps != {CNT_W{1'b1}}) steps <= steps + 1'b1;
                    end
                end
                st_done: begin
                    // Result pulse is registered on the way out, landing in the following cycle.
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= st_idle;
                end
                default: state <= st_idle;
            endcase
        end
    end

endmodule

// File: tb/tb_max4_search_ctrl.sv
// Self-checking bench for max4_search_ctrl: directed corner cases plus randomized operands
// compared against an order-statistics reference model.
module tb_max4_search_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a0, a1, a2, a3;
    logic        busy, done, tie;
    logic [1:0]  idx;
    logic [31:0] max_val;
    logic [31:0] steps;

    int n_checks = 0;
    int n_fail   = 0;

    max4_search_ctrl #(.WIDTH(32), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .start(start),
        .a0(a0), .a1(a1), .a2(a2), .a3(a3),
        .busy(busy), .done(done), .idx(idx), .tie(tie),
        .max_val(max_val), .steps(steps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: unique max wins; step count from order statistics of the operands.
    task automatic model(input logic [31:0] v0, v1, v2, v3,
                         output logic [1:0] e_idx, output logic e_tie,
                         output logic [31:0] e_max, output logic [31:0] e_steps);
        logic [31:0] v[4];
        logic [31:0] mx, second;
        logic [31:0] distinct[$];
        int cnt, am;
        v = '{v0, v1, v2, v3};
        mx = 0; am = 0;
        for (int i = 0; i < 4; i++) if (v[i] > mx) begin mx = v[i]; am = i; end
        cnt = 0;
        for (int i = 0; i < 4; i++) if (v[i] == mx) cnt++;
        second = 0;
        for (int i = 0; i < 4; i++) if (i != am && v[i] > second) second = v[i];
        for (int i = 0; i < 4; i++) begin
            bit seen = 0;
            foreach (distinct[j]) if (distinct[j] == v[i]) seen = 1;
            if (!seen && v[i] != 0) distinct.push_back(v[i]);
        end
        if (cnt == 1) begin
            e_idx = 2'(am); e_tie = 0; e_max = mx;
        end else begin
            e_idx = 0; e_tie = 1; e_max = 0;
        end
`ifdef MAX4_FAST_STEP_EN
        e_steps = 32'(distinct.size()) - ((cnt == 1) ? 32'd1 : 32'd0);
`else
        e_steps = (cnt == 1) ? second : mx;
`endif
    endtask

    // Runs one search; optionally re-pulses start one cycle into RUN with other operands.
    task automatic run_case(input logic [31:0] v0, v1, v2, v3, input bit interfere,
                            input string tag);
        logic [1:0]  e_idx;
        logic        e_tie;
        logic [31:0] e_max, e_steps;
        int k;
        bit got;
        model(v0, v1, v2, v3, e_idx, e_tie, e_max, e_steps);
        @(negedge clk);
        a0 = v0; a1 = v1; a2 = v2; a3 = v3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, ".busy"}, busy, 1);
        k = 0; got = 0;
        while (!got && k < 300) begin
            @(posedge clk); #1;
            k++;
            if (done) got = 1;
            if (interfere && k == 1) begin
                start = 1'b1; a0 = 0; a1 = 0; a2 = 32'd99; a3 = 0;
            end else begin
                start = 1'b0;
            end
        end
        check({tag, ".done_seen"}, got, 1);
        check({tag, ".latency"}, k, e_steps + 2);
        check({tag, ".idx"}, idx, e_idx);
        check({tag, ".tie"}, tie, e_tie);
        check({tag, ".max_val"}, max_val, e_max);
        check({tag, ".steps"}, steps, e_steps);
        @(posedge clk); #1;
        check({tag, ".done_pulse"}, done, 0);
        check({tag, ".hold_idx"}, idx, e_idx);
    endtask

    initial begin
        logic [31:0] v[4];
        rst = 1'b0; start = 1'b0; a0 = 0; a1 = 0; a2 = 0; a3 = 0;
        #12;
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.idx", idx, 0);
        check("rst.tie", tie, 0);
        check("rst.max_val", max_val, 0);
        check("rst.steps", steps, 0);
        @(negedge clk); rst = 1'b1;

        run_case(5, 3, 0, 1, 0, "basic");
        run_case(7, 0, 7, 2, 0, "tie7");
        run_case(0, 0, 9, 0, 0, "single");
        run_case(0, 0, 0, 0, 0, "zeros");
        run_case(0, 0, 0, 32'hFFFF_FFFF, 0, "allones");
        run_case(1, 0, 0, 32'h8000_0000, 0, "msb");
        run_case(5, 3, 0, 1, 1, "ignore_start");

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        a0 = 7; a1 = 0; a2 = 7; a3 = 2; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (2) @(posedge clk);
        #2; rst = 1'b0; #1;
        check("midrst.busy", busy, 0);
        check("midrst.idx", idx, 0);
        check("midrst.max_val", max_val, 0);
        check("midrst.steps", steps, 0);
        check("midrst.tie", tie, 0);
        @(negedge clk); rst = 1'b1;
        run_case(4, 9, 2, 6, 0, "after_rst");

        // Held start: back-to-back runs with a single idle cycle between them.
        @(negedge clk);
        a0 = 2; a1 = 1; a2 = 0; a3 = 0; start = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            check($sformatf("b2b.done%0d", k), done, (k % 4 == 3));
            check($sformatf("b2b.busy%0d", k), busy, (k % 4 != 3));
            if (k % 4 == 3) begin
                check($sformatf("b2b.idx%0d", k), idx, 0);
                check($sformatf("b2b.steps%0d", k), steps, 1);
            end
        end
        @(negedge clk); start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("b2b.idle", busy, 0);

        for (int n = 0; n < 24; n++) begin
            for (int i = 0; i < 4; i++) v[i] = $urandom_range(0, 40);
            if ($urandom_range(0, 3) == 0) v[$urandom_range(0, 3)] = v[$urandom_range(0, 3)];
            if ($urandom_range(0, 4) == 0) v[$urandom_range(0, 3)] = 0;
            run_case(v[0], v[1], v[2], v[3], 0, $sformatf("rnd%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
